// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the multiplexed seven-segment controller.
package seven_seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } slot_state_e;

    // Active-high segment patterns, bit 0 = a ... bit 6 = g.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

    // Map a logical "on" to the pin level for the chosen output polarity.
    function automatic logic drive_level(input logic on, input bit active_low);
        return on ^ active_low;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running prescaler; one-cycle tick on the terminal count.
module scan_tick_gen #(
    parameter int DIVIDE_BY = 17
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    logic [DIVIDE_BY-1:0] cnt;

    // Counter wraps naturally at 2^DIVIDE_BY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else          cnt <= cnt + 1'b1;
    end

    assign tick = &cnt;

endmodule

// File: rtl/seven_seg_mux.sv
// N-digit multiplexed seven-segment controller with dead time and
// frame-aligned double-buffered loads.
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DIVIDE_BY      = 17,
    parameter int BLANK_CYCLES   = 2,
    parameter int ACTIVE_LOW_OUT = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BC_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BC_W-1:0]  LAST_BC  = BC_W'(BLANK_CYCLES - 1);
    localparam bit AL = (ACTIVE_LOW_OUT != 0);

    logic tick, wrap_tick, accept, apply;

    logic [IDX_W-1:0] idx, idx_nxt;
    slot_state_e      state, state_nxt;
    logic [BC_W-1:0]  bcnt, bcnt_nxt;

    logic [NUM_DIGITS-1:0][3:0] pend_data, disp_data, disp_data_nxt;
    logic [NUM_DIGITS-1:0]      pend_blank, disp_blank, disp_blank_nxt;
    logic [NUM_DIGITS-1:0]      pend_dp, disp_dp, disp_dp_nxt;
    logic                       pend_valid;

    logic [NUM_DIGITS-1:0] an_on, an_d;
    logic [6:0]            seg_on, seg_d;
    logic                  dp_on, dp_d;

    scan_tick_gen #(.DIVIDE_BY(DIVIDE_BY)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign wrap_tick = tick && (idx == LAST_IDX);
    assign accept    = load_valid && load_ready;
    // Pending state is sampled before this cycle's accept, so a load taken
    // on the wrap tick itself waits for the next frame.
    assign apply     = wrap_tick && pend_valid;

    // Digit index advances once per slot.
    always_comb begin
        idx_nxt = idx;
        if (tick) idx_nxt = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end

    // Slot FSM next state: every tick restarts the dead time.
    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        if (tick) begin
            bcnt_nxt  = '0;
            state_nxt = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
        end else if (state == BLANK) begin
            if (BLANK_CYCLES == 0 || bcnt == LAST_BC) state_nxt = DRIVE;
            else                                      bcnt_nxt  = bcnt + 1'b1;
        end
    end

    // Index and slot FSM state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx   <= '0;
            state <= BLANK;
            bcnt  <= '0;
        end else begin
            idx   <= idx_nxt;
            state <= state_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    // Pending buffer and handshake; ready is simply "no load pending".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid <= 1'b0;
            load_ready <= 1'b1;
            pend_data  <= '0;
            pend_blank <= '0;
            pend_dp    <= '0;
        end else if (apply) begin
            pend_valid <= 1'b0;
            load_ready <= 1'b1;
        end else if (accept) begin
            pend_data  <= data_in;
            pend_blank <= blank_in;
            pend_dp    <= dp_in;
            pend_valid <= 1'b1;
            load_ready <= 1'b0;
        end
    end

    // Display contents swap only at the frame wrap.
    always_comb begin
        disp_data_nxt  = apply ? pend_data  : disp_data;
        disp_blank_nxt = apply ? pend_blank : disp_blank;
        disp_dp_nxt    = apply ? pend_dp    : disp_dp;
    end

    // Display registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_data  <= '0;
            disp_blank <= '1;
            disp_dp    <= '0;
        end else begin
            disp_data  <= disp_data_nxt;
            disp_blank <= disp_blank_nxt;
            disp_dp    <= disp_dp_nxt;
        end
    end

    // Logical output values for the coming cycle, then pin polarity.
    always_comb begin
        an_on  = '0;
        seg_on = '0;
        dp_on  = 1'b0;
        if (state_nxt == DRIVE && !disp_blank_nxt[idx_nxt]) begin
            an_on[idx_nxt] = 1'b1;
            seg_on         = hex_decode(disp_data_nxt[idx_nxt]);
            dp_on          = disp_dp_nxt[idx_nxt];
        end
        for (int i = 0; i < NUM_DIGITS; i++) an_d[i] = drive_level(an_on[i], AL);
        for (int i = 0; i < 7; i++)          seg_d[i] = drive_level(seg_on[i], AL);
        dp_d = drive_level(dp_on, AL);
    end

    // Registered pin outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an          <= {NUM_DIGITS{AL}};
            seg         <= {7{AL}};
            dp          <= AL;
            frame_start <= 1'b0;
        end else begin
            an          <= an_d;
            seg         <= seg_d;
            dp          <= dp_d;
            frame_start <= wrap_tick;
        end
    end

endmodule
